// File: rtl/i281_boot_pkg.sv
// Shared definitions for the i281 BIOS boot sequencer: geometry of the BIOS
// word banks, the instruction memory, and the loader state encoding.
package i281_boot_pkg;

  localparam int BIOS_NUM_WORDS = 16;
  localparam int INSTR_W        = 16;
  localparam int IMEM_ADDR_W    = 5;
  localparam int CHECKSUM_W     = 16;

  localparam int BIOS_LOW_BASE  = 0;
  localparam int BIOS_HIGH_BASE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } boot_state_e;

endpackage

// File: rtl/bios_word_mux.sv
// Combinational selection of one BIOS word from the flattened bank.
// Indices at or beyond NUM_WORDS select zero.
module bios_word_mux #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_W    = 16,
  parameter int IDX_W     = 5
) (
  input  logic [NUM_WORDS*WORD_W-1:0] i_bios_flat,
  input  logic [IDX_W-1:0]            i_idx,
  output logic [WORD_W-1:0]           o_word
);

  always_comb begin
    o_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (i_idx == IDX_W'(k)) o_word = i_bios_flat[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/bios_boot_loader.sv
// Copies the BIOS word bank into instruction memory after reset, holds the
// CPU until the copy completes, and publishes a mod-2^16 checksum of the load.
module bios_boot_loader
  import i281_boot_pkg::*;
#(
  parameter int NUM_WORDS = BIOS_NUM_WORDS,
  parameter int WORD_W    = INSTR_W,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = BIOS_LOW_BASE
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic [NUM_WORDS*WORD_W-1:0] bios_flat,
  input  logic                        imem_busy,
  input  logic                        reload_req,
  output logic                        imem_wr_en,
  output logic [ADDR_W-1:0]           imem_wr_addr,
  output logic [WORD_W-1:0]           imem_wr_data,
  output logic                        boot_done,
  output logic                        cpu_hold,
  output logic [CHECKSUM_W-1:0]       checksum
);

  localparam int                IDX_W    = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  boot_state_e           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CHECKSUM_W-1:0] r_checksum;
  logic                  r_boot_done;

  boot_state_e           w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [CHECKSUM_W-1:0] w_checksum_nxt;
  logic                  w_boot_done_nxt;
  logic [WORD_W-1:0]     w_word;
  logic                  w_accept;

  bios_word_mux #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .i_bios_flat (bios_flat),
    .i_idx       (r_idx),
    .o_word      (w_word)
  );

  assign w_accept = (r_state == LOAD) && !imem_busy;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_checksum_nxt  = r_checksum;
    w_boot_done_nxt = r_boot_done;
    imem_wr_en      = 1'b0;
    imem_wr_addr    = BASE;
    imem_wr_data    = '0;

    case (r_state)
      IDLE: begin
        w_state_nxt     = LOAD;
        w_idx_nxt       = '0;
        w_checksum_nxt  = '0;
        w_boot_done_nxt = 1'b0;
      end
      LOAD: begin
        imem_wr_en   = 1'b1;
        imem_wr_addr = BASE + ADDR_W'(r_idx);
        imem_wr_data = w_word;
        if (w_accept) begin
          w_checksum_nxt = r_checksum + CHECKSUM_W'(w_word);
          w_idx_nxt      = r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            w_state_nxt     = DONE;
            w_boot_done_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        // Reload skips IDLE so the first write is presented on the next cycle.
        if (reload_req) begin
          w_state_nxt     = LOAD;
          w_idx_nxt       = '0;
          w_checksum_nxt  = '0;
          w_boot_done_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_idx_nxt       = '0;
        w_checksum_nxt  = '0;
        w_boot_done_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_checksum  <= '0;
      r_boot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_checksum  <= w_checksum_nxt;
      r_boot_done <= w_boot_done_nxt;
    end
  end

  assign boot_done = r_boot_done;
  assign cpu_hold  = ~r_boot_done;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Directed bench for bios_boot_loader: nominal copy, stalls, checksum wrap,
// asynchronous reset mid-load, reload, and high/wrapping base addresses.
module tb_bios_boot_loader;

  localparam int NW = 16;

  logic           clk;
  logic           rst_n;
  logic [NW*16-1:0] bios_flat;
  logic           imem_busy;
  logic           reload_req;

  logic           wr_en, b16_wr_en, b24_wr_en;
  logic [4:0]     wr_addr, b16_wr_addr, b24_wr_addr;
  logic [15:0]    wr_data, b16_wr_data, b24_wr_data;
  logic           boot_done, b16_boot_done, b24_boot_done;
  logic           cpu_hold, b16_cpu_hold, b24_cpu_hold;
  logic [15:0]    checksum, b16_checksum, b24_checksum;

  logic [15:0]    words [NW];
  int             n_checks = 0;
  int             n_errors = 0;

  bios_boot_loader dut (
    .Clock (clk), .Reset_n (rst_n), .bios_flat (bios_flat),
    .imem_busy (imem_busy), .reload_req (reload_req),
    .imem_wr_en (wr_en), .imem_wr_addr (wr_addr), .imem_wr_data (wr_data),
    .boot_done (boot_done), .cpu_hold (cpu_hold), .checksum (checksum)
  );

  bios_boot_loader #(.BASE_ADDR(16)) dut_b16 (
    .Clock (clk), .Reset_n (rst_n), .bios_flat (bios_flat),
    .imem_busy (imem_busy), .reload_req (reload_req),
    .imem_wr_en (b16_wr_en), .imem_wr_addr (b16_wr_addr), .imem_wr_data (b16_wr_data),
    .boot_done (b16_boot_done), .cpu_hold (b16_cpu_hold), .checksum (b16_checksum)
  );

  bios_boot_loader #(.BASE_ADDR(24)) dut_b24 (
    .Clock (clk), .Reset_n (rst_n), .bios_flat (bios_flat),
    .imem_busy (imem_busy), .reload_req (reload_req),
    .imem_wr_en (b24_wr_en), .imem_wr_addr (b24_wr_addr), .imem_wr_data (b24_wr_data),
    .boot_done (b24_boot_done), .cpu_hold (b24_cpu_hold), .checksum (b24_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_flat();
    for (int k = 0; k < NW; k++) bios_flat[k*16 +: 16] = words[k];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},     32'(wr_en),       32'd0);
    check({tag, "_addr"},   32'(wr_addr),     32'd0);
    check({tag, "_data"},   32'(wr_data),     32'd0);
    check({tag, "_done"},   32'(boot_done),   32'd0);
    check({tag, "_hold"},   32'(cpu_hold),    32'd1);
    check({tag, "_sum"},    32'(checksum),    32'd0);
    check({tag, "_b16adr"}, 32'(b16_wr_addr), 32'd16);
    check({tag, "_b24adr"}, 32'(b24_wr_addr), 32'd24);
  endtask

  // Called at a falling edge with the loaders presenting word 0.
  // Words in stall_lo..stall_hi are held busy for two extra cycles.
  task automatic do_load(input string tag, input int stall_lo, input int stall_hi,
                         input int reload_at, input int abort_at);
    logic [15:0] run_sum;
    logic [4:0]  a24;
    run_sum = 16'h0000;
    for (int k = 0; k < NW; k++) begin
      int holds;
      if (k == abort_at) begin
        imem_busy  = 1'b0;
        reload_req = 1'b0;
        return;
      end
      holds = (k >= stall_lo && k <= stall_hi) ? 2 : 0;
      a24   = 5'(24 + k);
      for (int h = 0; h <= holds; h++) begin
        imem_busy  = (h < holds);
        reload_req = (k == reload_at && h == 0);
        check($sformatf("%s_en[%0d.%0d]", tag, k, h),     32'(wr_en),       32'd1);
        check($sformatf("%s_addr[%0d.%0d]", tag, k, h),   32'(wr_addr),     32'(k));
        check($sformatf("%s_data[%0d.%0d]", tag, k, h),   32'(wr_data),     32'(words[k]));
        check($sformatf("%s_done[%0d.%0d]", tag, k, h),   32'(boot_done),   32'd0);
        check($sformatf("%s_hold[%0d.%0d]", tag, k, h),   32'(cpu_hold),    32'd1);
        check($sformatf("%s_sum[%0d.%0d]", tag, k, h),    32'(checksum),    32'(run_sum));
        check($sformatf("%s_b16adr[%0d.%0d]", tag, k, h), 32'(b16_wr_addr), 32'(16 + k));
        check($sformatf("%s_b24adr[%0d.%0d]", tag, k, h), 32'(b24_wr_addr), 32'(a24));
        @(posedge clk);
        @(negedge clk);
      end
      run_sum = run_sum + words[k];
    end
    imem_busy  = 1'b0;
    reload_req = 1'b0;
    check({tag, "_end_done"},   32'(boot_done),   32'd1);
    check({tag, "_end_hold"},   32'(cpu_hold),    32'd0);
    check({tag, "_end_en"},     32'(wr_en),       32'd0);
    check({tag, "_end_addr"},   32'(wr_addr),     32'd0);
    check({tag, "_end_data"},   32'(wr_data),     32'd0);
    check({tag, "_end_b16adr"}, 32'(b16_wr_addr), 32'd16);
    check({tag, "_end_b24adr"}, 32'(b24_wr_addr), 32'd24);
    check({tag, "_end_b24don"}, 32'(b24_boot_done), 32'd1);
  endtask

  // Pulses reload_req from DONE; returns at the falling edge presenting word 0.
  task automatic do_reload();
    reload_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload_req = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_busy  = 1'b0;
    reload_req = 1'b0;
    for (int k = 0; k < NW; k++) words[k] = 16'h0000;
    words[1] = 16'hE01E;
    set_flat();

    #12;
    check_idle_outputs("rst");

    // Nominal copy: edge 1 leaves IDLE, edges 2..17 accept words 0..15.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    do_load("nom", -1, -1, -1, -1);
    check("nom_final_sum", 32'(checksum), 32'h0000E01E);

    // DONE ignores imem_busy and holds the checksum.
    imem_busy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_busy = 1'b0;
    check("done_hold_done", 32'(boot_done), 32'd1);
    check("done_hold_sum",  32'(checksum),  32'h0000E01E);
    check("done_hold_en",   32'(wr_en),     32'd0);

    // Reload, stalls at words 3 and 4, and an ignored reload pulse mid-load.
    do_reload();
    do_load("stall", 3, 4, 8, -1);
    check("stall_final_sum", 32'(checksum), 32'h0000E01E);

    // Asynchronous reset after 7 accepted writes, then a full restart.
    do_reload();
    do_load("abort", -1, -1, -1, 7);
    check("abort_pre_sum", 32'(checksum), 32'h0000E01E);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    do_load("rerun", -1, -1, -1, -1);
    check("rerun_final_sum", 32'(checksum), 32'h0000E01E);

    // Sixteen words of F000 wrap the checksum to zero.
    for (int k = 0; k < NW; k++) words[k] = 16'hF000;
    set_flat();
    do_reload();
    do_load("wrap", -1, -1, -1, -1);
    check("wrap_final_sum", 32'(checksum), 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
